shiftreg_ctrl: RTL and testbench

Sequencing controller for the N-bit shift register datapath. It accepts a parallel word over a valid/ready handshake and loads it into the shift register. It then issues exactly N paced shift strobes (MSB first on the serial line) and captures the word shifted in on `sin` as a received word on a second valid/ready port. It sits between the processor-side bus logic and the shiftreg instance, which gains a shift-enable input driven by this block.

---
 rtl/shiftreg_ctrl.sv | 145 ++++++++++++++
 tb/tb_shiftreg_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_ctrl.sv
// shiftreg_ctrl: load/shift/capture sequencer for an N-bit shift register.
// Accepts a tx word, paces N shift strobes, returns the shifted-in word on rx.
module shiftreg_ctrl #(
  parameter int N   = 8,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic [N-1:0] rx_data,
  output logic         rx_valid,
  input  logic         rx_ready,
  output logic         sr_load,
  output logic [N-1:0] sr_data,
  output logic         sr_shift,
  input  logic [N-1:0] sr_q,
  input  logic         sr_sout,
  output logic         ser_out,
  output logic         ser_frame,
  output logic         busy
);

  if (N < 2) begin : g_n_chk
    $error("shiftreg_ctrl: N must be >= 2");
  end
  if (DIV < 1) begin : g_div_chk
    $error("shiftreg_ctrl: DIV must be >= 1");
  end

  localparam int BW = $clog2(N);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [N-1:0]  sr_data_q, sr_data_d;
  logic [N-1:0]  rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          div_last;
  logic          accept;

  assign div_last = (div_cnt_q == DIV_LAST);
  assign accept   = (state_q == IDLE) && tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT: begin
        if (div_last && bit_cnt_q == BIT_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx_ready is held low while reset is asserted
  always_comb begin
    tx_ready  = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    ser_frame = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy     = 1'b0;
        tx_ready = reset && (!rx_valid_q || rx_ready);
      end
      LOAD:  sr_load = 1'b1;
      SHIFT: begin
        ser_frame = 1'b1;
        sr_shift  = div_last;
      end
      DONE:    busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    sr_data_d  = sr_data_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (accept) sr_data_d = tx_data;
    if (state_q == LOAD) begin
      bit_cnt_d = '0;
      div_cnt_d = '0;
    end else if (state_q == SHIFT) begin
      if (div_last) begin
        div_cnt_d = '0;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (state_q == DONE) begin
      rx_data_d  = sr_q;
      rx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      sr_data_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      sr_data_q  <= sr_data_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign sr_data  = sr_data_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign ser_out  = ser_frame & sr_sout;

endmodule

// File: tb/tb_shiftreg_ctrl.sv
// Bench for shiftreg_ctrl: unit 0 is DIV=1 in loopback,
// unit 1 is DIV=3 with sin driven from a per-frame bit pattern.
module tb_shiftreg_ctrl;
  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [N-1:0] tx_data [2];
  logic [1:0]   tx_valid;
  logic [1:0]   rx_ready;
  logic         sin_b;
  logic [N-1:0] q [2];

  wire  [N-1:0] rx_data [2];
  wire  [N-1:0] sr_data [2];
  wire  [1:0]   tx_ready, rx_valid, sr_load, sr_shift;
  wire  [1:0]   ser_out, ser_frame, busy, sr_sout, sin;

  int n_tests = 0;
  int n_fail  = 0;

  assign sin     = {sin_b, ser_out[0]};
  assign sr_sout = {q[1][N-1], q[0][N-1]};

  // behavioural shift register attached to each controller
  always_ff @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!reset) q[u] <= '0;
      else if (sr_load[u]) q[u] <= sr_data[u];
      else if (sr_shift[u]) q[u] <= {q[u][N-2:0], sin[u]};
    end
  end

  shiftreg_ctrl #(.N(N), .DIV(1)) u_a (
    .clk(clk), .reset(reset),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .rx_ready(rx_ready[0]),
    .sr_load(sr_load[0]), .sr_data(sr_data[0]),
    .sr_shift(sr_shift[0]),
    .sr_q(q[0]), .sr_sout(sr_sout[0]),
    .ser_out(ser_out[0]), .ser_frame(ser_frame[0]),
    .busy(busy[0])
  );

  shiftreg_ctrl #(.N(N), .DIV(3)) u_b (
    .clk(clk), .reset(reset),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .rx_ready(rx_ready[1]),
    .sr_load(sr_load[1]), .sr_data(sr_data[1]),
    .sr_shift(sr_shift[1]),
    .sr_q(q[1]), .sr_sout(sr_sout[1]),
    .ser_out(ser_out[1]), .ser_frame(ser_frame[1]),
    .busy(busy[1])
  );

  function automatic int dv(int u);
    return (u == 0) ? 1 : 3;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(int u, logic [N-1:0] word);
    tx_valid[u] = 1'b1;
    tx_data[u]  = word;
    #1;
    n_tests++;
    if (tx_ready[u] !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready u%0d: got %b want 1", u, tx_ready[u]);
    end
    tick;
  endtask

  // Runs from the LOAD cycle to the first IDLE cycle; abort>0 resets
  // the design right after that many strobes.
  task automatic body(int u, logic [N-1:0] word,
                      logic [N-1:0] pat, int abort);
    int d;
    int j;
    logic [N-1:0] exp_rx;
    logic exp_bit;
    d = dv(u);
    exp_rx = (u == 0) ? word : pat;
    n_tests++;
    if ({sr_load[u], busy[u], tx_ready[u], sr_shift[u]} !== 4'b1100) begin
      n_fail++;
      $display("FAIL load_cycle u%0d: ld/busy/rdy/sh=%b%b%b%b want 1100",
               u, sr_load[u], busy[u], tx_ready[u], sr_shift[u]);
    end
    for (int c = 1; c <= N * d; c++) begin
      tx_valid[u] = 1'($urandom);
      tx_data[u]  = N'($urandom);
      tick;
      if (abort > 0 && c == abort * d + 1) begin
        tx_valid[u] = 1'b0;
        reset = 1'b0;
        tick;
        n_tests++;
        if ({busy[u], ser_frame[u], rx_valid[u], sr_load[u],
             sr_shift[u], tx_ready[u]} !== 6'b0) begin
          n_fail++;
          $display("FAIL abort_reset u%0d: b/f/v/l/s/r=%b%b%b%b%b%b want 0",
                   u, busy[u], ser_frame[u], rx_valid[u], sr_load[u],
                   sr_shift[u], tx_ready[u]);
        end
        reset = 1'b1;
        tick;
        n_tests++;
        if (tx_ready[u] !== 1'b1 || busy[u] !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_release u%0d: rdy=%b busy=%b want 1 0",
                   u, tx_ready[u], busy[u]);
        end
        return;
      end
      j = (c - 1) / d;
      if (u == 1) sin_b = pat[N-1-j];
      exp_bit = word[N-1-j];
      n_tests++;
      if (ser_frame[u] !== 1'b1 || sr_load[u] !== 1'b0 ||
          busy[u] !== 1'b1 || tx_ready[u] !== 1'b0) begin
        n_fail++;
        $display("FAIL shift_ctl u%0d c%0d: fr/ld/busy/rdy=%b%b%b%b want 1010",
                 u, c, ser_frame[u], sr_load[u], busy[u], tx_ready[u]);
      end
      n_tests++;
      if (sr_shift[u] !== ((c % d) == 0)) begin
        n_fail++;
        $display("FAIL strobe u%0d c%0d: got %b want %b",
                 u, c, sr_shift[u], (c % d) == 0);
      end
      n_tests++;
      if (ser_out[u] !== exp_bit || sr_data[u] !== word) begin
        n_fail++;
        $display("FAIL ser_out u%0d c%0d: got %b/%h want %b/%h",
                 u, c, ser_out[u], sr_data[u], exp_bit, word);
      end
    end
    tx_valid[u] = 1'b0;
    tick;
    n_tests++;
    if ({busy[u], ser_frame[u], rx_valid[u], sr_shift[u]} !== 4'b1000 ||
        sr_data[u] !== word) begin
      n_fail++;
      $display("FAIL done_cycle u%0d: b/f/v/s=%b%b%b%b data=%h want 1000 %h",
               u, busy[u], ser_frame[u], rx_valid[u], sr_shift[u],
               sr_data[u], word);
    end
    tick;
    n_tests++;
    if (rx_valid[u] !== 1'b1 || rx_data[u] !== exp_rx ||
        busy[u] !== 1'b0 || tx_ready[u] !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_word u%0d: v=%b data=%h busy=%b rdy=%b want 1 %h 0 0",
               u, rx_valid[u], rx_data[u], busy[u], tx_ready[u], exp_rx);
    end
  endtask

  task automatic consume(int u);
    rx_ready[u] = 1'b1;
    tick;
    rx_ready[u] = 1'b0;
    n_tests++;
    if (rx_valid[u] !== 1'b0) begin
      n_fail++;
      $display("FAIL consume u%0d: rx_valid=%b want 0", u, rx_valid[u]);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tx_valid = 2'b00;
    rx_ready = 2'b00;
    tx_data[0] = '0;
    tx_data[1] = '0;
    sin_b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick;
      for (int u = 0; u < 2; u++) begin
        n_tests++;
        if ({tx_ready[u], rx_valid[u], sr_load[u], sr_shift[u],
             ser_out[u], ser_frame[u], busy[u], rx_data[u],
             sr_data[u]} !== '0) begin
          n_fail++;
          $display("FAIL reset_vals u%0d: r/v/l/s/o/f/b=%b%b%b%b%b%b%b rx=%h sd=%h want 0",
                   u, tx_ready[u], rx_valid[u], sr_load[u], sr_shift[u],
                   ser_out[u], ser_frame[u], busy[u], rx_data[u], sr_data[u]);
        end
      end
    end
    reset = 1'b1;
    tick;
    n_tests++;
    if (tx_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release: tx_ready=%b want 11", tx_ready);
    end
  endtask

  task automatic test_loopback;
    start(0, 8'b10101010);
    body(0, 8'b10101010, '0, 0);
    consume(0);
  endtask

  task automatic test_pacing;
    sin_b = 1'b1;
    start(1, 8'h00);
    body(1, 8'h00, 8'hFF, 0);
    consume(1);
  endtask

  task automatic test_backpressure;
    logic [N-1:0] w1;
    logic [N-1:0] w2;
    w1 = N'($urandom);
    w2 = N'($urandom);
    start(0, w1);
    body(0, w1, '0, 0);
    tx_valid[0] = 1'b1;
    tx_data[0]  = w2;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++;
      if (tx_ready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready k%0d: got %b want 0", k, tx_ready[0]);
      end
      tick;
      n_tests++;
      if (sr_load[0] !== 1'b0 || busy[0] !== 1'b0 ||
          rx_valid[0] !== 1'b1 || rx_data[0] !== w1) begin
        n_fail++;
        $display("FAIL bp_hold k%0d: ld=%b busy=%b v=%b rx=%h want 0 0 1 %h",
                 k, sr_load[0], busy[0], rx_valid[0], rx_data[0], w1);
      end
    end
    rx_ready[0] = 1'b1;
    start(0, w2);
    rx_ready[0] = 1'b0;
    n_tests++;
    if (rx_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_consume: rx_valid=%b want 0", rx_valid[0]);
    end
    body(0, w2, '0, 0);
    consume(0);
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] w;
    for (int u = 0; u < 2; u++) begin
      w = N'($urandom);
      start(u, w);
      for (int k = 0; k < 3; k++) begin
        logic [N-1:0] pat;
        pat = N'($urandom);
        body(u, w, pat, 0);
        w = N'($urandom);
        rx_ready[u] = 1'b1;
        start(u, w);
        rx_ready[u] = 1'b0;
      end
      body(u, w, 8'hFF, 0);
      consume(u);
    end
  endtask

  task automatic test_random;
    int u;
    logic [N-1:0] w;
    logic [N-1:0] p;
    for (int i = 0; i < 8; i++) begin
      u = i % 2;
      w = N'($urandom);
      p = N'($urandom);
      repeat ($urandom_range(0, 3)) tick;
      start(u, w);
      body(u, w, p, 0);
      repeat ($urandom_range(0, 2)) tick;
      consume(u);
    end
  endtask

  task automatic test_reset_midframe;
    start(0, 8'h3C);
    body(0, 8'h3C, '0, 4);
    for (int k = 0; k < 12; k++) begin
      tick;
      n_tests++;
      if (rx_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL midframe_idle k%0d: v=%b busy=%b want 0 0",
                 k, rx_valid[0], busy[0]);
      end
    end
    start(0, 8'h5A);
    body(0, 8'h5A, '0, 0);
    consume(0);
  endtask

  task automatic test_idle;
    tx_valid = 2'b00;
    for (int k = 0; k < 50; k++) begin
      rx_ready = 2'($urandom);
      tick;
      n_tests++;
      if ({sr_load, sr_shift, ser_frame, busy} !== '0) begin
        n_fail++;
        $display("FAIL idle k%0d: ld=%b sh=%b fr=%b busy=%b want 0",
                 k, sr_load, sr_shift, ser_frame, busy);
      end
    end
    rx_ready = 2'b00;
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_pacing;
    test_backpressure;
    test_back_to_back;
    test_random;
    test_reset_midframe;
    test_idle;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
